control_suma_16b: RTL

CONTROL_SUMA_16B -- requirements
Module: control_suma_16b

---
 rtl/control_suma_16b.sv | 139 +++++++++++++
 1 files changed

// File: rtl/control_suma_16b.sv
// control_suma_16b: two-requester 16-bit adder built around one shared 4-bit
// ripple nibble adder. An addition takes four nibble cycles: accept, then
// ADD x4, then a one-cycle DONE pulse, then back to IDLE.
// Arbitration is round-robin; A has priority after reset.
// Optional build macro: SUMA_SATURACION_EN clamps suma to 16'hFFFF on carry-out.
module control_suma_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] num1_a,
  input  logic [15:0] num2_a,
  input  logic [15:0] num1_b,
  input  logic [15:0] num2_b,
  input  logic        cin_a,
  input  logic        cin_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        done_a,
  output logic        done_b,
  output logic [15:0] suma,
  output logic        cout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_b_q, owner_b_d;  // current owner of the adder (1 = B)
  logic        last_b_q, last_b_d;    // last grant went to B
  logic [15:0] n1_q, n1_d, n2_q, n2_d;
  logic [15:0] acc_q, acc_d;          // partial sum, filled one nibble per cycle
  logic        carry_q, carry_d;
  logic [1:0]  nib_q, nib_d;
  logic [15:0] suma_q, suma_d;
  logic        cout_q, cout_d;

  logic [3:0]  nib_a, nib_b, nib_s;
  logic [4:0]  rc;
  logic        nib_co;
  logic [15:0] sum_full;
  logic        win_b;

  // The single shared 4-bit ripple adder on the selected operand nibble
  always_comb begin
    nib_a = n1_q[{nib_q, 2'b00} +: 4];
    nib_b = n2_q[{nib_q, 2'b00} +: 4];
    nib_s = '0;
    rc    = '0;
    rc[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_s[i]  = nib_a[i] ^ nib_b[i] ^ rc[i];
      rc[i+1]   = (nib_a[i] & nib_b[i]) | (rc[i] & (nib_a[i] ^ nib_b[i]));
    end
    nib_co   = rc[4];
    sum_full = {nib_s, acc_q[11:0]};
  end

  // Next-state, operand capture, nibble sequencing and result latch
  always_comb begin
    state_d   = state_q;
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
    n1_d      = n1_q;
    n2_d      = n2_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    nib_d     = nib_q;
    suma_d    = suma_q;
    cout_d    = cout_q;
    // B wins if alone, or if both request and A was granted last
    win_b     = req_b & (~req_a | ~last_b_q);
    case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          owner_b_d = win_b;
          last_b_d  = win_b;
          n1_d      = win_b ? num1_b : num1_a;
          n2_d      = win_b ? num2_b : num2_a;
          carry_d   = win_b ? cin_b  : cin_a;
          nib_d     = 2'd0;
          state_d   = ADD;
        end
      end
      ADD: begin
        acc_d[{nib_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_co;
        nib_d   = nib_q + 2'd1;
        if (nib_q == 2'd3) begin
          state_d = DONE;
          cout_d  = nib_co;
`ifdef SUMA_SATURACION_EN
          suma_d  = nib_co ? 16'hFFFF : sum_full;
`else
          suma_d  = sum_full;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      n1_q      <= '0;
      n2_q      <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      nib_q     <= 2'd0;
      suma_q    <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      nib_q     <= nib_d;
      suma_q    <= suma_d;
      cout_q    <= cout_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign gnt_a  = busy & ~owner_b_q;
  assign gnt_b  = busy &  owner_b_q;
  assign done_a = (state_q == DONE) & ~owner_b_q;
  assign done_b = (state_q == DONE) &  owner_b_q;
  assign suma   = suma_q;
  assign cout   = cout_q;

endmodule
